// File: rtl/max_pool_1_engine.sv
// -----------------------------------------------------------------------------
// max_pool_1_engine
//   2x2 / stride-2 signed max-pool for layer 1. Walks every output window
//   (ocol fastest, then orow, then channel), reads the four window elements
//   from the conv-1 output BRAM, keeps a running signed max and writes one
//   pooled word per window through port A of the max_pool_1 BRAM.
//   An odd last row / column of the input map is never read.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin one pass (only honoured while idle)
//   busy                  high for the whole pass, low in the done cycle
//   done                  one-cycle pulse after the last output word
//   in_bram_addr/en/dout  conv-1 BRAM read port (1-cycle read latency)
//   BRAM_PORTA_0_*        max_pool_1 BRAM port A (write only)
// -----------------------------------------------------------------------------
module max_pool_1_engine #(
  parameter int          IN_H     = 28,
  parameter int          IN_W     = 28,
  parameter int          CHANNELS = 8,
  parameter logic [31:0] IN_BASE  = 32'h0,
  parameter logic [31:0] OUT_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] in_bram_addr,
  output logic        in_bram_en,
  input  logic [31:0] in_bram_dout,
  output logic [31:0] BRAM_PORTA_0_addr,
  output logic [31:0] BRAM_PORTA_0_din,
  output logic        BRAM_PORTA_0_en,
  output logic [3:0]  BRAM_PORTA_0_we
);

  localparam int OH  = IN_H / 2;
  localparam int OW  = IN_W / 2;
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RW  = (OH > 1) ? $clog2(OH) : 1;
  localparam int OCW = (OW > 1) ? $clog2(OW) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_e;

  state_e           state_q;
  logic [1:0]       k_q;
  logic [CW-1:0]    c_q;
  logic [RW-1:0]    orow_q;
  logic [OCW-1:0]   ocol_q;
  logic [31:0]      max_q;
  logic             busy_q, done_q, in_en_q, pa_en_q;
  logic [31:0]      in_addr_q, pa_addr_q, pa_din_q;
  logic [3:0]       pa_we_q;

  // k selects the window element: k[1] = row offset, k[0] = column offset
  function automatic logic [31:0] in_addr_f(input logic [CW-1:0]  c,
                                            input logic [RW-1:0]  orow,
                                            input logic [OCW-1:0] ocol,
                                            input logic [1:0]     k);
    logic [31:0] row, col, idx;
    row = 32'(orow) * 32'd2 + {31'd0, k[1]};
    col = 32'(ocol) * 32'd2 + {31'd0, k[0]};
    idx = 32'(c) * 32'(IN_H * IN_W) + row * 32'(IN_W) + col;
    return IN_BASE + (idx << 2);
  endfunction

  function automatic logic [31:0] out_addr_f(input logic [CW-1:0]  c,
                                             input logic [RW-1:0]  orow,
                                             input logic [OCW-1:0] ocol);
    logic [31:0] idx;
    idx = 32'(c) * 32'(OH * OW) + 32'(orow) * 32'(OW) + 32'(ocol);
    return OUT_BASE + (idx << 2);
  endfunction

  // next window position
  logic           last_col, last_row, last_ch, last_win;
  logic [OCW-1:0] ocol_n;
  logic [RW-1:0]  orow_n;
  logic [CW-1:0]  c_n;

  always_comb begin
    last_col = (ocol_q == OCW'(OW - 1));
    last_row = (orow_q == RW'(OH - 1));
    last_ch  = (c_q == CW'(CHANNELS - 1));
    last_win = last_col && last_row && last_ch;
    ocol_n   = last_col ? '0 : ocol_q + 1'b1;
    orow_n   = orow_q;
    c_n      = c_q;
    if (last_col) begin
      orow_n = last_row ? '0 : orow_q + 1'b1;
      if (last_row) c_n = c_q + 1'b1;
    end
  end

  logic        gt;
  logic [31:0] max_fin;
  assign gt      = $signed(in_bram_dout) > $signed(max_q);
  assign max_fin = gt ? in_bram_dout : max_q;

  // Read data for the element addressed in FETCH k arrives one cycle later,
  // so datum k-1 is captured in FETCH k and the last datum in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      c_q       <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      max_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      in_en_q   <= 1'b0;
      in_addr_q <= '0;
      pa_en_q   <= 1'b0;
      pa_we_q   <= '0;
      pa_addr_q <= '0;
      pa_din_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q  <= 1'b0;
          pa_en_q <= 1'b0;
          pa_we_q <= '0;
          in_en_q <= 1'b0;
          if (start) begin
            busy_q    <= 1'b1;
            k_q       <= '0;
            c_q       <= '0;
            orow_q    <= '0;
            ocol_q    <= '0;
            in_en_q   <= 1'b1;
            in_addr_q <= in_addr_f('0, '0, '0, 2'd0);
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          // first datum loads the max outright so all-negative windows work
          if (k_q == 2'd1)      max_q <= in_bram_dout;
          else if (k_q != 2'd0) max_q <= max_fin;
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            in_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            in_addr_q <= in_addr_f(c_q, orow_q, ocol_q, k_q + 2'd1);
          end
        end
        S_DRAIN: begin
          max_q     <= max_fin;
          pa_din_q  <= max_fin;
          pa_addr_q <= out_addr_f(c_q, orow_q, ocol_q);
          pa_en_q   <= 1'b1;
          pa_we_q   <= 4'hF;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          pa_en_q <= 1'b0;
          pa_we_q <= '0;
          if (last_win) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            c_q       <= c_n;
            orow_q    <= orow_n;
            ocol_q    <= ocol_n;
            in_en_q   <= 1'b1;
            in_addr_q <= in_addr_f(c_n, orow_n, ocol_n, 2'd0);
            state_q   <= S_FETCH;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign in_bram_addr      = in_addr_q;
  assign in_bram_en        = in_en_q;
  assign BRAM_PORTA_0_addr = pa_addr_q;
  assign BRAM_PORTA_0_din  = pa_din_q;
  assign BRAM_PORTA_0_en   = pa_en_q;
  assign BRAM_PORTA_0_we   = pa_we_q;

endmodule

// File: tb/tb_max_pool_1_engine.sv
// -----------------------------------------------------------------------------
// tb_max_pool_1_engine
//   Two engines: A (4x4, 1 channel) and B (5x5, 3 channels, IN_BASE=0x200,
//   OUT_BASE=0x100). Each has a 1-cycle-latency read BRAM model and a write
//   monitor that pops expected (addr,data) pairs from a scoreboard queue
//   filled by a behavioural pooling model before each pass.
// -----------------------------------------------------------------------------
module tb_max_pool_1_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- engine A ----------------
  logic        a_start = 1'b0, a_busy, a_done, a_ien, a_oen;
  logic [31:0] a_iaddr, a_dout, a_oaddr, a_din;
  logic [3:0]  a_we;
  logic signed [31:0] mem_a [16];
  logic [63:0] q_a [$];
  int a_wr = 0;

  max_pool_1_engine #(.IN_H(4), .IN_W(4), .CHANNELS(1), .IN_BASE(32'h0), .OUT_BASE(32'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .in_bram_addr(a_iaddr), .in_bram_en(a_ien), .in_bram_dout(a_dout),
    .BRAM_PORTA_0_addr(a_oaddr), .BRAM_PORTA_0_din(a_din),
    .BRAM_PORTA_0_en(a_oen), .BRAM_PORTA_0_we(a_we));

  always @(posedge clk) if (a_ien) a_dout <= (a_iaddr < 32'd64) ? mem_a[a_iaddr[5:2]] : 32'hDEAD_BEEF;

  always @(negedge clk) if (rst_n && a_oen) begin
    a_wr++;
    if (q_a.size() == 0) begin
      total++; bad++;
      $error("FAIL a_unexpected_wr observed=%0h expected=none", a_oaddr);
    end else begin
      logic [63:0] e;
      e = q_a.pop_front();
      chk("a_wr_addr_data", {a_oaddr, a_din}, e);
      chk("a_we", {60'd0, a_we}, 64'hF);
    end
  end

  task automatic push_a();
    for (int orow = 0; orow < 2; orow++)
      for (int ocol = 0; ocol < 2; ocol++) begin
        logic signed [31:0] m;
        m = mem_a[(2*orow)*4 + 2*ocol];
        if (mem_a[(2*orow)*4 + 2*ocol + 1] > m) m = mem_a[(2*orow)*4 + 2*ocol + 1];
        if (mem_a[(2*orow+1)*4 + 2*ocol] > m)   m = mem_a[(2*orow+1)*4 + 2*ocol];
        if (mem_a[(2*orow+1)*4 + 2*ocol+1] > m) m = mem_a[(2*orow+1)*4 + 2*ocol + 1];
        q_a.push_back({32'(4 * (orow*2 + ocol)), m});
      end
  endtask

  // full pass on A; optional stray start pulse at cycle 10
  task automatic run_a(input string tag, input bit repulse);
    int cyc, wr0;
    wr0 = a_wr;
    push_a();
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    cyc = 1;
    while (!a_done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5)  chk({tag, "_busy_mid"}, {63'd0, a_busy}, 64'd1);
      if (repulse && cyc == 10) a_start = 1'b1;
      if (cyc == 11) a_start = 1'b0;
    end
    chk({tag, "_done_latency"}, 64'(cyc), 64'd25);
    chk({tag, "_busy_at_done"}, {63'd0, a_busy}, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_len"}, {63'd0, a_done}, 64'd0);
    chk({tag, "_wr_count"}, 64'(a_wr - wr0), 64'd4);
    chk({tag, "_queue_empty"}, 64'(q_a.size()), 64'd0);
  endtask

  // ---------------- engine B ----------------
  logic        b_start = 1'b0, b_busy, b_done, b_ien, b_oen;
  logic [31:0] b_iaddr, b_dout, b_oaddr, b_din;
  logic [3:0]  b_we;
  logic signed [31:0] mem_b [75];
  logic [63:0] q_b [$];
  int b_wr = 0, b_bad_rd = 0;
  logic [31:0] b_addr9 = '0;

  max_pool_1_engine #(.IN_H(5), .IN_W(5), .CHANNELS(3), .IN_BASE(32'h200), .OUT_BASE(32'h100)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .in_bram_addr(b_iaddr), .in_bram_en(b_ien), .in_bram_dout(b_dout),
    .BRAM_PORTA_0_addr(b_oaddr), .BRAM_PORTA_0_din(b_din),
    .BRAM_PORTA_0_en(b_oen), .BRAM_PORTA_0_we(b_we));

  always @(posedge clk) if (b_ien) begin
    int idx;
    idx = int'((b_iaddr - 32'h200) >> 2);
    b_dout <= (b_iaddr >= 32'h200 && idx < 75) ? mem_b[idx] : 32'hDEAD_BEEF;
  end

  // every driven read must be aligned, in range, and never on row 4 / col 4
  always @(negedge clk) if (rst_n && b_ien) begin
    int idx;
    idx = int'((b_iaddr - 32'h200) >> 2);
    if (b_iaddr[1:0] != 2'b00 || b_iaddr < 32'h200 || idx >= 75 ||
        (idx % 25) / 5 == 4 || idx % 5 == 4) b_bad_rd++;
  end

  always @(negedge clk) if (rst_n && b_oen) begin
    b_wr++;
    if (b_wr == 9) b_addr9 = b_oaddr;
    if (q_b.size() == 0) begin
      total++; bad++;
      $error("FAIL b_unexpected_wr observed=%0h expected=none", b_oaddr);
    end else begin
      logic [63:0] e;
      e = q_b.pop_front();
      chk("b_wr_addr_data", {b_oaddr, b_din}, e);
    end
  end

  task automatic push_b();
    for (int c = 0; c < 3; c++)
      for (int orow = 0; orow < 2; orow++)
        for (int ocol = 0; ocol < 2; ocol++) begin
          logic signed [31:0] m;
          m = mem_b[c*25 + (2*orow)*5 + 2*ocol];
          for (int k = 1; k < 4; k++)
            if (mem_b[c*25 + (2*orow + k/2)*5 + 2*ocol + k%2] > m)
              m = mem_b[c*25 + (2*orow + k/2)*5 + 2*ocol + k%2];
          q_b.push_back({32'h100 + 32'(4 * (c*4 + orow*2 + ocol)), m});
        end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc, wr0;
    for (int i = 0; i < 16; i++) mem_a[i] = 32'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {62'd0, a_busy, b_busy}, 64'd0);
    chk("rst_done",  {62'd0, a_done, b_done}, 64'd0);
    chk("rst_en",    {60'd0, a_ien, a_oen, b_ien, b_oen}, 64'd0);
    chk("rst_we",    {56'd0, a_we, b_we}, 64'd0);
    chk("rst_addr",  {a_iaddr, a_oaddr}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ascending map 0..15 -> {5,7,13,15}
    run_a("t1", 1'b0);

    // all-negative map -16..-1 -> {-11,-9,-3,-1}
    for (int i = 0; i < 16; i++) mem_a[i] = 32'(i - 16);
    run_a("t2", 1'b0);

    // stray start mid-pass, with ties and extreme values in the map
    mem_a = '{32'h8000_0000, 32'h7FFF_FFFF, 3, 3, 32'h8000_0000, 0, 3, 3,
              -5, -5, 9, -1, -5, -6, 32'h8000_0001, 2};
    run_a("t5", 1'b1);

    // reset mid-window aborts the pass
    for (int i = 0; i < 16; i++) mem_a[i] = 32'(i);
    push_a();
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_abort_en_we_busy", {57'd0, a_ien, a_oen, a_we, a_busy}, 64'd0);
    q_a.delete();
    wr0 = a_wr;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_wr_after_abort", 64'(a_wr - wr0), 64'd0);
    chk("t6_no_done_after_abort", {62'd0, a_done, a_busy}, 64'd0);
    run_a("t6_restart", 1'b0);

    // engine B: odd 5x5 map, 3 channels, random data with forced ties
    for (int i = 0; i < 75; i++) mem_b[i] = $urandom;
    mem_b[1] = mem_b[0];
    mem_b[30] = 32'hFFFF_FFFF; mem_b[31] = 32'hFFFF_FFFF; mem_b[35] = 32'h8000_0000; mem_b[36] = 32'hFFFF_FFFE;
    push_b();
    wr0 = b_wr;
    b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    cyc = 1;
    while (!b_done && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t4_done_latency", 64'(cyc), 64'd73);
    chk("t4_wr_count", 64'(b_wr - wr0), 64'd12);
    chk("t4_ch2_first_addr", {32'd0, b_addr9}, 64'h120);
    chk("t4_queue_empty", 64'(q_b.size()), 64'd0);
    chk("t3_no_row4_col4_reads", 64'(b_bad_rd), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
